// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave front-end.
//   SPI_ADDR_SIZE / SPI_FRAME_W : default RAM address width and MOSI frame width
//   CMD_*                       : frame command field encodings (frame bits [9:8])
//   spi_state_e                 : slave FSM states
package spi_pkg;

  localparam int unsigned SPI_ADDR_SIZE = 8;
  localparam int unsigned SPI_FRAME_W   = SPI_ADDR_SIZE + 2;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WAIT_TX,
    SEND,
    DONE
  } spi_state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: shift-left register, serial-in/parallel-out with parallel load.
//   clk, rst_n : clock, asynchronous active-low reset
//   shift_en   : shift q left by one, sin enters at bit 0
//   load       : load pdata (takes priority over shift_en)
//   sin        : serial input
//   pdata      : parallel load value
//   q          : register contents (MSB is the oldest serial bit)
module spi_shift_reg #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             load,
  input  logic             sin,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= pdata;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], sin};
    end
  end

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave front-end between an external SPI master and the command RAM.
//   Receives ADDR_SIZE+2 bit MOSI frames (MSB first), presents them on rx_data with a
//   one-cycle rx_valid strobe, and for rd-data frames (cmd 11) serialises the RAM's
//   tx_data byte back on MISO (MSB first). All inputs are synchronous to clk.
// Ports:
//   clk, rst_n          : system clock, asynchronous active-low reset
//   SS_n, MOSI          : slave select (active low), serial data in
//   MISO                : registered serial data out
//   rx_data, rx_valid   : assembled frame and its one-cycle strobe
//   tx_data, tx_valid   : read byte from RAM and its one-cycle strobe
// Build option:
//   SPI_SLAVE_RD_ORDER_EN : a rd-data frame is forwarded only after a rd-addr frame;
//                           otherwise it is dropped silently.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = SPI_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [7:0]           tx_data,
  input  logic                 tx_valid
);

  localparam int unsigned FW = ADDR_SIZE + 2;
  // The last frame bit is taken straight from MOSI, so only FW-1 bits are stored.
  localparam int unsigned SW = FW - 1;
  localparam logic [3:0] RX_LAST = 4'(FW - 1);
  localparam logic [3:0] TX_LAST = 4'd7;

  spi_state_e      state, state_nxt;
  logic [3:0]      bit_cnt, cnt_nxt;
  logic            miso_nxt, rx_valid_nxt, rx_load;
  logic            sr_shift, sr_load;
  logic [SW-1:0]   sr_q, sr_pdata;
  logic [1:0]      cmd;
  logic            rd_frame, rd_ok, rx_last;

  // Byte sits right-aligned so bit 6 of the stored value is always the next MISO bit.
  assign sr_pdata = SW'(tx_data);
  assign cmd      = sr_q[SW-1:SW-2];
  assign rx_last  = (bit_cnt == RX_LAST);

  always_comb begin
    rd_frame = 1'b0;
    case (cmd)
      CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR: rd_frame = 1'b0;
      CMD_RD_DATA:                           rd_frame = 1'b1;
      default:                               rd_frame = 1'b0;
    endcase
  end

`ifdef SPI_SLAVE_RD_ORDER_EN
  logic rd_seen, rd_seen_nxt;
  assign rd_ok = !rd_frame || rd_seen;
`else
  assign rd_ok = 1'b1;
`endif

  spi_shift_reg #(.WIDTH(SW)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (sr_shift),
    .load     (sr_load),
    .sin      (MOSI),
    .pdata    (sr_pdata),
    .q        (sr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = RECV;
        RECV:    if (rx_last) state_nxt = (rd_frame && rd_ok) ? WAIT_TX : DONE;
        WAIT_TX: if (tx_valid) state_nxt = SEND;
        SEND:    if (bit_cnt == TX_LAST) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    sr_shift     = 1'b0;
    sr_load      = 1'b0;
    cnt_nxt      = bit_cnt;
    miso_nxt     = MISO;
    rx_valid_nxt = 1'b0;
    rx_load      = 1'b0;
`ifdef SPI_SLAVE_RD_ORDER_EN
    rd_seen_nxt  = rd_seen;
`endif
    if (SS_n) begin
      cnt_nxt  = '0;
      miso_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sr_shift = 1'b1;
          cnt_nxt  = 4'd1;
        end
        RECV: begin
          sr_shift = 1'b1;
          if (rx_last) begin
            cnt_nxt = '0;
            if (rd_ok) begin
              rx_valid_nxt = 1'b1;
              rx_load      = 1'b1;
            end
`ifdef SPI_SLAVE_RD_ORDER_EN
            if (cmd == CMD_RD_ADDR) rd_seen_nxt = 1'b1;
            else if (rd_frame)      rd_seen_nxt = 1'b0;
`endif
          end else begin
            cnt_nxt = bit_cnt + 4'd1;
          end
        end
        WAIT_TX: begin
          if (tx_valid) begin
            sr_load  = 1'b1;
            miso_nxt = tx_data[7];
            cnt_nxt  = '0;
          end
        end
        SEND: begin
          if (bit_cnt == TX_LAST) begin
            miso_nxt = 1'b0;
            cnt_nxt  = '0;
          end else begin
            sr_shift = 1'b1;
            miso_nxt = sr_q[6];
            cnt_nxt  = bit_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      MISO     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
`ifdef SPI_SLAVE_RD_ORDER_EN
      rd_seen  <= 1'b0;
`endif
    end else begin
      bit_cnt  <= cnt_nxt;
      MISO     <= miso_nxt;
      rx_valid <= rx_valid_nxt;
      if (rx_load) rx_data <= {sr_q, MOSI};
`ifdef SPI_SLAVE_RD_ORDER_EN
      rd_seen  <= rd_seen_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: self-checking bench for spi_slave (table vectors, hand-written
// corner sequences, randomized frames against a frame-level reference model).
module tb_spi_slave;
  import spi_pkg::*;

`ifdef SPI_SLAVE_RD_ORDER_EN
  localparam bit ORDER = 1'b1;
`else
  localparam bit ORDER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  int         total = 0;
  int         bad = 0;
  int         mon_pulses = 0;
  logic [9:0] mon_data = '0;
  logic       m_flag = 1'b0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      mon_pulses++;
      mon_data = rx_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: which frames are forwarded and what byte returns.
  function automatic void model_step(input logic [9:0] f, input int nbits, input logic [7:0] rb,
                                     output logic ev, output logic [7:0] em);
    ev = 1'b0;
    em = 8'h00;
    if (nbits == 10) begin
      if (!(ORDER && f[9:8] == 2'b11 && !m_flag)) begin
        ev = 1'b1;
        if (f[9:8] == 2'b11) em = rb;
      end
      if (ORDER && ev) begin
        if (f[9:8] == 2'b10)      m_flag = 1'b1;
        else if (f[9:8] == 2'b11) m_flag = 1'b0;
      end
    end
  endfunction

  // Sends nbits of frame f, plays the RAM for rd-data frames, then raises SS_n.
  task automatic do_frame(input logic [9:0] f, input logic [7:0] rb, input int nbits, input logic spur,
                          output int pulses, output logic [9:0] data, output logic [7:0] mbyte,
                          output logic junk);
    int p0;
    p0 = mon_pulses;
    junk = 1'b0;
    mbyte = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      junk |= MISO;
      SS_n = 1'b0;
      MOSI = f[9-i];
      tx_valid = spur;
      tx_data = spur ? 8'hFF : 8'h00;
    end
    @(negedge clk);
    junk |= MISO;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    if (nbits == 10 && rx_valid && rx_data[9:8] == 2'b11) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data = rb;
      @(negedge clk);
      tx_valid = 1'b0;
      mbyte[7] = MISO;
      for (int b = 6; b >= 0; b--) begin
        @(negedge clk);
        mbyte[b] = MISO;
      end
      @(negedge clk);
      junk |= MISO;
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (2) begin
      @(negedge clk);
      junk |= MISO;
    end
    pulses = mon_pulses - p0;
    data = mon_data;
  endtask

  task automatic run_frame(input string name, input logic [9:0] f, input logic [7:0] rb, input int nbits,
                           input logic spur, input logic ev, input logic [7:0] em);
    int pulses;
    logic [9:0] data;
    logic [7:0] mbyte;
    logic junk;
    do_frame(f, rb, nbits, spur, pulses, data, mbyte, junk);
    check({name, "_pulses"}, pulses, ev ? 1 : 0);
    if (ev) check({name, "_rxdata"}, data, f);
    check({name, "_miso_byte"}, mbyte, em);
    check({name, "_miso_idle"}, junk, 1'b0);
  endtask

  typedef struct {
    logic [9:0] frame;
    logic [7:0] rbyte;
    logic       spur;
    logic       ev;
    logic [7:0] emiso;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic ev, acc;
    logic [7:0] em, rb;
    logic [9:0] f;
    int nb;

    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_miso", MISO, 1'b0);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_rx_data", rx_data, 10'h000);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;

    // spurious tx_valid while idle
    acc = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data = 8'hFF;
      acc |= MISO;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    acc |= MISO;
    check("spur_idle_miso", acc, 1'b0);
    check("spur_idle_state", 32'(dut.state), 32'(IDLE));

    tbl[0] = '{10'h35A, 8'h5A, 1'b0, !ORDER, ORDER ? 8'h00 : 8'h5A};
    tbl[1] = '{10'h0A5, 8'h00, 1'b1, 1'b1, 8'h00};
    tbl[2] = '{10'h203, 8'h00, 1'b0, 1'b1, 8'h00};
    tbl[3] = '{10'h3AB, 8'hC3, 1'b0, 1'b1, 8'hC3};
    tbl[4] = '{10'h3AB, 8'h3C, 1'b0, !ORDER, ORDER ? 8'h00 : 8'h3C};
    tbl[5] = '{10'h1F0, 8'h00, 1'b0, 1'b1, 8'h00};
    for (int i = 0; i < 6; i++) begin
      model_step(tbl[i].frame, 10, tbl[i].rbyte, ev, em);
      run_frame($sformatf("tbl%0d", i), tbl[i].frame, tbl[i].rbyte, 10, tbl[i].spur, tbl[i].ev, tbl[i].emiso);
    end

    // abort after 6 bits, then a full frame
    model_step(10'h2AA, 6, 8'h00, ev, em);
    run_frame("abort6", 10'h2AA, 8'h00, 6, 1'b0, ev, em);
    model_step(10'h1F0, 10, 8'h00, ev, em);
    run_frame("after_abort", 10'h1F0, 8'h00, 10, 1'b0, ev, em);

    // read abandoned by SS_n high in WAIT_TX; late tx_valid must be ignored
    model_step(10'h203, 10, 8'h00, ev, em);
    run_frame("abandon_pre", 10'h203, 8'h00, 10, 1'b0, ev, em);
    f = 10'h355;
    model_step(f, 10, 8'hFF, ev, em);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = f[9-i];
    end
    @(negedge clk);
    check("abandon_rx_valid", rx_valid, 1'b1);
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    acc = MISO;
    repeat (3) begin
      @(negedge clk);
      acc |= MISO;
    end
    check("abandon_miso", acc, 1'b0);
    check("abandon_state", 32'(dut.state), 32'(IDLE));

    // reset in the middle of SEND
    model_step(10'h203, 10, 8'h00, ev, em);
    run_frame("rst_pre", 10'h203, 8'h00, 10, 1'b0, ev, em);
    f = 10'h3C0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = f[9-i];
    end
    @(negedge clk);
    check("rst_rx_valid", rx_valid, 1'b1);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data = 8'hF0;
    @(negedge clk);
    tx_valid = 1'b0;
    check("rst_bit7", MISO, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_bit4", MISO, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_miso", MISO, 1'b0);
    check("rst_mid_rx_valid", rx_valid, 1'b0);
    check("rst_mid_state", 32'(dut.state), 32'(IDLE));
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_flag = 1'b0;
    model_step(10'h0A5, 10, 8'h00, ev, em);
    run_frame("post_rst", 10'h0A5, 8'h00, 10, 1'b0, ev, em);

    // randomized frames, occasional aborts
    for (int n = 0; n < 40; n++) begin
      f = 10'($urandom);
      rb = 8'($urandom);
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : 10;
      model_step(f, nb, rb, ev, em);
      run_frame($sformatf("rnd%0d", n), f, rb, nb, 1'b0, ev, em);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
